// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path: FSM states and width/value helpers.
package audio_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} pdm_state_t;

   function automatic int midscale(input int bitdepth);
      return 1 << (bitdepth - 1);
   endfunction

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; pointers carry an extra MSB so full and empty differ.
module sample_fifo
   import audio_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign level = r_wr_ptr - r_rd_ptr;

   // A push into a full FIFO is refused even when a pop happens on the same edge.
   assign w_do_push = push && !full && !rst;
   assign w_do_pop  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pdm_dac.sv
// Audio output stage: buffers offset-binary samples and plays them at a fixed
// rate through a first-order sigma-delta modulator onto a 1-bit pin.
module pdm_dac
   import audio_pkg::*;
#(
   parameter int BITDEPTH   = 12,
   parameter int FIFO_DEPTH = 4,
   parameter int SAMPLE_DIV = 1000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [BITDEPTH-1:0]                sample_in,
   input  logic                               sample_valid,
   output logic                               sample_ready,
   input  logic                               enable,
   output logic                               pdm_out,
   output logic                               underrun,
   output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

   localparam int LW = level_width(FIFO_DEPTH);
   localparam int CW = $clog2(SAMPLE_DIV);
   localparam logic [BITDEPTH-1:0] MID         = BITDEPTH'(midscale(BITDEPTH));
   localparam logic [LW-1:0]       PRIME_LEVEL = LW'(FIFO_DEPTH / 2);
   localparam logic [CW-1:0]       TICK_LAST   = CW'(SAMPLE_DIV - 1);

   pdm_state_t          r_state;
   logic [CW-1:0]       r_tick_cnt;
   logic [BITDEPTH-1:0] r_acc;
   logic [BITDEPTH-1:0] r_cur;
   logic                r_carry;
   logic                r_pdm;
   logic                r_underrun;

   logic                w_full;
   logic                w_empty;
   logic                w_tick;
   logic [BITDEPTH-1:0] w_head;
   logic [LW-1:0]       w_level;
   logic [BITDEPTH:0]   w_sum;

   assign w_tick       = enable && (r_state == RUN) && (r_tick_cnt == TICK_LAST);
   assign w_sum        = {1'b0, r_acc} + {1'b0, r_cur};
   assign sample_ready = !rst && !w_full;
   assign fifo_level   = w_level;
   assign pdm_out      = r_pdm;
   assign underrun     = r_underrun;

   sample_fifo #(
      .WIDTH (BITDEPTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (sample_valid),
      .push_data (sample_in),
      .pop       (w_tick),
      .pop_data  (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (w_level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_tick_cnt <= '0;
         r_acc      <= '0;
         r_cur      <= MID;
         r_carry    <= 1'b0;
         r_pdm      <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= 1'b0;
         // Carry is staged once more so a new sample reaches the pin two edges after its pop.
         r_pdm      <= r_carry;
         if (!enable) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cur   <= MID;
            r_carry <= 1'b0;
            r_pdm   <= 1'b0;
         end else begin
            case (r_state)
               IDLE: r_state <= PRIME;
               PRIME: begin
                  if (w_level >= PRIME_LEVEL) begin
                     r_state    <= RUN;
                     r_tick_cnt <= TICK_LAST;
                  end
               end
               RUN: begin
                  {r_carry, r_acc} <= w_sum;
                  if (r_tick_cnt == TICK_LAST) begin
                     r_tick_cnt <= '0;
                     if (!w_empty) r_cur      <= w_head;
                     else          r_underrun <= 1'b1;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/pdm_dac.md
# pdm_dac

Single-clock audio output stage that accepts unsigned offset-binary samples from the synth voices/mixer over a valid/ready handshake. Samples are buffered in a small FIFO and released at a fixed sample rate derived from the system clock. Each sample is converted to a 1-bit pulse-density stream by a first-order sigma-delta modulator that drives the board's audio pin through an RC filter. The block is the consumer end of the oscillator sample path.

## Interface
- `BITDEPTH`, 12: sample width; unsigned, midscale = 2^(BITDEPTH-1).
- `FIFO_DEPTH`, 4: sample FIFO entries; power of two, ≥2.
- `SAMPLE_DIV`, 1000: clk cycles per output sample period; ≥2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  BITDEPTH  sample data, offset-binary.
- `sample_valid`  in  1  `sample_in` is valid.
- `sample_ready`  out  1  FIFO can accept; a push occurs when `sample_valid & sample_ready`.
- `enable`  in  1  run the modulator; low forces IDLE.
- `pdm_out`  out  1  registered pulse-density output.
- `underrun`  out  1  one-cycle pulse when a sample tick finds the FIFO empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states:
  - IDLE: `pdm_out`=0, accumulator cleared, current sample = midscale, tick counter held.
  - PRIME: wait for `fifo_level` ≥ FIFO_DEPTH/2.
  - RUN: modulate and pop at sample ticks.
- FSM transitions:
  - IDLE→PRIME when `enable`=1.
  - PRIME→RUN when the level condition is met.
  - Any state→IDLE when `enable`=0, taking effect the next cycle. FIFO contents are retained.
- FIFO accepts pushes in every state. `sample_ready` = !full, computed from registered occupancy.
- Tick counter runs only in RUN. On entry it is loaded with SAMPLE_DIV-1, so the first tick fires in the first RUN cycle; later ticks follow every SAMPLE_DIV cycles, counting 0..SAMPLE_DIV-1 and wrapping.
- At a tick:
  - If the FIFO is non-empty: pop the head into the current-sample register.
  - Otherwise: hold the current sample and pulse `underrun`. The FSM stays in RUN and does not re-prime.
- Modulator, every RUN cycle:
  - {carry, acc} = acc + cur, with a BITDEPTH-bit accumulator and BITDEPTH+1-bit sum.
  - `pdm_out` <= carry.
  - Density of ones = cur / 2^BITDEPTH. Over any aligned 2^BITDEPTH-cycle window with constant cur, exactly cur ones are produced.
- Simultaneous push and pop:
  - Non-empty, non-full FIFO: both happen; level unchanged.
  - Full FIFO: only the pop; `sample_ready` rises next cycle.
  - Empty FIFO at a tick: underrun; the push still lands.

## Timing
- Reset values: `pdm_out`=0, `underrun`=0, `fifo_level`=0, `sample_ready`=0 while `rst` is high and 1 on the first cycle after. FSM=IDLE, acc=0, cur=midscale, tick counter=0.
- Reset mid-operation: FIFO is emptied, all state returns to reset values on the next edge, and an in-flight push is dropped.
- Push-to-level latency: 1 cycle. `fifo_level` and `sample_ready` update on the edge after the push.
- Pop-to-use: a sample popped at tick edge T is used by the modulator from cycle T+1. Its first effect on `pdm_out` is visible after edge T+2.
- `underrun` is asserted for exactly the cycle following the failing tick.
- `enable` falling: `pdm_out`=0 from the next edge.

## Structure
- Shared package `audio_pkg` holds:
  - localparam function for midscale, 2^(BITDEPTH-1);
  - FSM state enum `pdm_state_t` {IDLE, PRIME, RUN};
  - `clog2`-based width helper for level ports.
- Sub-module `sample_fifo` (synchronous, single clock, BITDEPTH × FIFO_DEPTH):
  - ports push/pop/full/empty/level;
  - wrap-around pointers with an extra MSB for full/empty discrimination.
- Top level contains the FSM, tick counter and modulator.

## Test plan
- Reset, then check idle outputs: `sample_ready`=1 after `rst` deasserts, `pdm_out`=0, `fifo_level`=0, no `underrun`.
- Density (BITDEPTH=8, SAMPLE_DIV=256, FIFO_DEPTH=4):
  - push 0x40 ×4, enable → exactly 64 ones per 256-cycle window after the first sample is loaded;
  - repeat with 0x00 → 0 ones and 0xFF → 255 ones.
- Priming: enable with 1 sample queued → FSM stays in PRIME and `pdm_out`=0. Push a second sample → RUN next cycle and first pop in the first RUN cycle.
- Full/backpressure: hold `sample_valid`=1 with 4 queued → `sample_ready`=0 until a tick pop, then 1 for one push, after which level returns to 4.
- Underrun: stop pushing in RUN → `underrun` pulses once per tick while the FIFO is empty, and `pdm_out` density stays at the last sample. Resume pushing → no further pulses.
- Mid-run disable and reset: drop `enable` during RUN → `pdm_out`=0 next cycle and FIFO level retained. Assert `rst` → level 0 and all outputs at reset values next cycle.
